psum_buffer_drain: RTL
======================

// Module: psum_buffer_drain
// PURPOSE
//  Partial-sum buffer on the far side of the accumulating convolution writer.
//  Serves the writer's read port (1-cycle latency) and write port during accumulation.
//  Streams the finished feature map out on a valid/ready interface toward the next layer,
//  with optional ReLU. Sits between the conv accumulator and the layer output / DMA stage.
// PARAMETERS
//  DataWidth  32  word width (IEEE-754 single; sign = MSB)
//  AddrWidth  16  address width; depth = 2**AddrWidth words
// PORTS
//  Clk          in   1          clock
//  Rst          in   1          synchronous, active-high reset
//  acc_rd_addr  in   AddrWidth  accumulator read address
//  acc_rd_data  out  DataWidth  word at acc_rd_addr, registered, valid 1 cycle after the address
//  acc_wr_addr  in   AddrWidth  accumulator write address
//  acc_wr_data  in   DataWidth  accumulator write data
//  acc_wr_en    in   1          write strobe
//  drain_start  in   1          1-cycle pulse: begin streaming words 0..drain_count-1
//  drain_count  in   AddrWidth+1  number of words to stream; sampled on drain_start
//  relu_en      in   1          sampled on drain_start; 1 = clamp negative words to 0
//  out_data     out  DataWidth  stream data
//  out_valid    out  1          stream valid
//  out_ready    in   1          stream ready from downstream
//  out_last     out  1          high with the final word of the drain
//  busy         out  1          high while in DRAIN
//  done         out  1          1-cycle pulse after the last word handshakes
// BEHAVIOUR
//  Reset: acc_rd_data=0, out_data=0, out_valid=0, out_last=0, busy=0, done=0, FSM=IDLE,
//   counters and skid FIFO cleared. RAM contents are not reset.
//  RAM: simple dual port. Writes are accepted in every state.
//   Read-first: a read of the address being written in the same cycle returns the old word.
//  Read port mux:
//   IDLE -> acc_rd_addr drives the RAM read.
//   DRAIN -> the drain counter drives the RAM read; acc_rd_data holds its last value.
//  FSM:
//   IDLE -> DRAIN on drain_start with drain_count>0. Latches count and relu_en;
//    rd_ptr=0, sent=0, busy=1 from the next cycle.
//   IDLE -> DONE on drain_start with drain_count==0. No output words.
//   DRAIN -> DONE when the word with sent==count-1 handshakes (out_valid&out_ready).
//   DONE -> IDLE after 1 cycle. done=1 only in DONE; busy=0.
//   drain_start while not IDLE is ignored.
//  Drain datapath:
//   2-entry output FIFO plus 1-cycle RAM latency.
//   A read issues when rd_ptr<count and (fifo occupancy + reads in flight) < 2; rd_ptr increments.
//   The read word enters the FIFO on the next cycle.
//   ReLU applies on FIFO entry: if relu_en and MSB=1, the word becomes 0. Includes -0.0 -> 0.
//   out_valid = FIFO non-empty; out_data/out_last = FIFO head.
//   out_last is tagged at read issue when rd_ptr==count-1.
//   Latency: drain_start at cycle t -> first out_valid at t+3 (t+1 latch, t+2 read, t+3 FIFO).
//   With out_ready held high, throughput is 1 word/cycle with no bubbles.
//   out_data/out_last stay stable while out_valid=1 and out_ready=0.
//  Width rules: counters are AddrWidth+1 bits.
//   drain_count > 2**AddrWidth is clamped to 2**AddrWidth; no address wrap inside a drain.
//  Reset mid-drain: drain aborts immediately, FIFO flushed, no done pulse, outputs -> reset values.
// TESTING
//  Write 0..15 at addr 0..15; acc_rd_addr=5 -> acc_rd_data=word5 next cycle.
//  Same cycle: write addr 3=0x40000000 and read addr 3 -> old word; read next cycle -> 0x40000000.
//  drain_count=16, relu_en=0, out_ready=1:
//   16 words in address order, first out_valid at t+3, out_last on word 15, done 1 cycle later.
//  relu_en=1, addr1=0xBF800000 (-1.0), addr2=0x80000000 -> out words 1,2 = 0x00000000; positives unchanged.
//  Random out_ready (50%) over 64 words: no loss, duplication or reorder; data stable while stalled.
//  Edge cases:
//   drain_count=0 -> done pulse, out_valid never asserted.
//   Rst at word 7 -> out_valid=0 next cycle, no done, new drain_start restarts at word 0.

Source files
------------

// File: rtl/psum_buffer_drain.sv
// Partial-sum buffer with drain streamer.
// Holds the conv accumulator's partial sums (1-cycle read, write every cycle) and,
// on drain_start, streams words 0..drain_count-1 over valid/ready with optional ReLU.
// Ports:
//   Clk, Rst                 clock, synchronous active-high reset
//   acc_rd_addr/acc_rd_data  accumulator read port, data registered 1 cycle after address
//   acc_wr_addr/_data/_en    accumulator write port, accepted in every state
//   drain_start/count        start pulse and word count (sampled on the pulse)
//   relu_en                  sampled on drain_start; clamps negative words to 0
//   out_data/valid/ready/last  output stream
//   busy, done               drain in progress / 1-cycle completion pulse
module psum_buffer_drain #(
    parameter int unsigned DataWidth = 32,
    parameter int unsigned AddrWidth = 16
) (
    input  logic                 Clk,
    input  logic                 Rst,
    input  logic [AddrWidth-1:0] acc_rd_addr,
    output logic [DataWidth-1:0] acc_rd_data,
    input  logic [AddrWidth-1:0] acc_wr_addr,
    input  logic [DataWidth-1:0] acc_wr_data,
    input  logic                 acc_wr_en,
    input  logic                 drain_start,
    input  logic [AddrWidth:0]   drain_count,
    input  logic                 relu_en,
    output logic [DataWidth-1:0] out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 out_last,
    output logic                 busy,
    output logic                 done
);

    localparam int unsigned Depth      = 2 ** AddrWidth;
    localparam int unsigned CountWidth = AddrWidth + 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DRAIN = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t                state;
    logic [DataWidth-1:0]  mem [Depth];
    logic [AddrWidth-1:0]  rd_addr;
    logic [DataWidth-1:0]  ram_q;
    logic [CountWidth-1:0] start_count;
    logic [CountWidth-1:0] count_q;
    logic [CountWidth-1:0] rd_ptr;
    logic [CountWidth-1:0] sent;
    logic                  relu_q;
    logic                  rd_pend;
    logic                  pend_last;
    logic                  rd_issue;
    logic                  pop;
    logic                  push;
    logic [1:0]            occ;
    logic [1:0]            occ_next;
    logic [DataWidth-1:0]  entry_data;
    logic [DataWidth-1:0]  tail_data;
    logic                  tail_last;

    // Read-address mux, count clamp, read-issue throttle and ReLU on FIFO entry
    always_comb begin
        rd_addr     = (state == S_DRAIN) ? rd_ptr[AddrWidth-1:0] : acc_rd_addr;
        start_count = (drain_count > CountWidth'(Depth)) ? CountWidth'(Depth) : drain_count;
        pop         = out_valid & out_ready;
        push        = rd_pend;
        // Occupancy counts this cycle's pop so a steady ready stream has no bubbles.
        rd_issue    = (state == S_DRAIN) && (rd_ptr < count_q) &&
                      (({1'b0, occ} - {2'b00, pop} + {2'b00, rd_pend}) < 3'd2);
        occ_next    = occ - {1'b0, pop} + {1'b0, push};
        entry_data  = (relu_q && ram_q[DataWidth-1]) ? '0 : ram_q;
    end

    // Dual-port RAM: one read port shared between accumulator and drain (read-first)
    always_ff @(posedge Clk) begin
        if (acc_wr_en) begin
            mem[acc_wr_addr] <= acc_wr_data;
        end
        if (state == S_DRAIN) begin
            ram_q <= mem[rd_addr];
        end
        if (Rst) begin
            acc_rd_data <= '0;
        end else if (state != S_DRAIN) begin
            acc_rd_data <= mem[rd_addr];
        end
    end

    // Control FSM, read pointer and 2-entry output FIFO (head is the output register)
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state     <= S_IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            count_q   <= '0;
            relu_q    <= 1'b0;
            rd_ptr    <= '0;
            sent      <= '0;
            rd_pend   <= 1'b0;
            pend_last <= 1'b0;
            occ       <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
            tail_data <= '0;
            tail_last <= 1'b0;
        end else begin
            done      <= 1'b0;
            rd_pend   <= rd_issue;
            pend_last <= rd_issue && (rd_ptr == count_q - CountWidth'(1));
            if (rd_issue) begin
                rd_ptr <= rd_ptr + CountWidth'(1);
            end

            if (pop) begin
                if (occ == 2'd2) begin
                    out_data <= tail_data;
                    out_last <= tail_last;
                    if (push) begin
                        tail_data <= entry_data;
                        tail_last <= pend_last;
                    end
                end else if (push) begin
                    out_data <= entry_data;
                    out_last <= pend_last;
                end
            end else if (push) begin
                if (occ == 2'd0) begin
                    out_data <= entry_data;
                    out_last <= pend_last;
                end else begin
                    tail_data <= entry_data;
                    tail_last <= pend_last;
                end
            end
            occ       <= occ_next;
            out_valid <= (occ_next != 2'd0);

            case (state)
                S_IDLE: begin
                    if (drain_start) begin
                        if (start_count != '0) begin
                            state   <= S_DRAIN;
                            busy    <= 1'b1;
                            count_q <= start_count;
                            relu_q  <= relu_en;
                            rd_ptr  <= '0;
                            sent    <= '0;
                        end else begin
                            state <= S_DONE;
                            done  <= 1'b1;
                        end
                    end
                end
                S_DRAIN: begin
                    if (pop) begin
                        sent <= sent + CountWidth'(1);
                        if (sent == count_q - CountWidth'(1)) begin
                            state <= S_DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
